// File: rtl/inv_shift_rows_stream_pkg.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_stream_pkg
// Shared AES geometry constants, bank flag encoding and the ShiftRows source
// index helper used by the byte-serial InvShiftRows engine.
// ---------------------------------------------------------------------------
package inv_shift_rows_stream_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_ROWS        = 4;
  localparam int AES_COLS        = 4;

  // Occupancy flag for each ping-pong bank.
  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_flag_t;

  // Bytes are column-major (k = 4c + r), so the row is k[1:0] and the column is
  // k[3:2]. The column arithmetic wraps mod 4 for free in a 2-bit result.
  function automatic logic [3:0] shift_rows_src(input logic [3:0] k,
                                                input logic       inverse);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] src_c;
    r     = k[1:0];
    c     = k[3:2];
    src_c = inverse ? (c - r) : (c + r);
    return {src_c, r};
  endfunction

endpackage

// File: rtl/inv_shift_rows_stream_idx.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_idx
// Combinational output-position to source-position map for (Inv)ShiftRows.
//   INVERSE : 1 = InvShiftRows, 0 = forward ShiftRows
//   k       : output byte position 0..15
//   src     : input byte position that lands at position k
// ---------------------------------------------------------------------------
module inv_shift_rows_idx
  import inv_shift_rows_stream_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic [3:0] k,
  output logic [3:0] src
);

  assign src = shift_rows_src(k, INVERSE);

endmodule

// File: rtl/inv_shift_rows_stream.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_stream
// Byte-serial AES (Inv)ShiftRows engine. A 16-byte state is written one byte
// per cycle into one of two ping-pong banks; a full bank is read back one byte
// per cycle in permuted order. The two banks allow fill and drain to overlap
// so the stream sustains one byte per cycle.
//   INVERSE   : 1 = InvShiftRows, 0 = forward ShiftRows
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   in_data   : input byte, block order b0..b15
//   in_valid  : in_data is valid
//   in_ready  : a byte can be accepted this cycle
//   out_data  : permuted output byte
//   out_valid : out_data is valid
//   out_ready : sink accepts out_data
//   out_last  : marks the 16th output byte of a block
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module inv_shift_rows_stream
  import inv_shift_rows_stream_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam logic [3:0] LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

  logic [AES_BLOCK_BYTES-1:0][7:0] bank [2];
  bank_flag_t                      flag [2];

  logic       wb;
  logic       rb;
  logic [3:0] wcnt;
  logic [3:0] rcnt;
  logic [3:0] rd_src;
  logic       wr_fire;
  logic       rd_fire;

  inv_shift_rows_idx #(
    .INVERSE (INVERSE)
  ) u_idx (
    .k   (rcnt),
    .src (rd_src)
  );

  // Writer may only fill a bank the reader has released; reader may only
  // drain a bank the writer has completed, so the two never touch one bank.
  assign in_ready  = (flag[wb] == BANK_FREE);
  assign out_valid = (flag[rb] == BANK_FULL);
  assign out_data  = bank[rb][rd_src];
  assign out_last  = out_valid && (rcnt == LAST_IDX);

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;

  // Completing a write and completing a read in the same cycle hit different
  // banks, so both flag updates can land on the same edge without priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank[0] <= '0;
      bank[1] <= '0;
      flag[0] <= BANK_FREE;
      flag[1] <= BANK_FREE;
      wb      <= 1'b0;
      rb      <= 1'b0;
      wcnt    <= 4'd0;
      rcnt    <= 4'd0;
    end else begin
      if (wr_fire) begin
        bank[wb][wcnt] <= in_data;
        wcnt           <= wcnt + 4'd1;
        if (wcnt == LAST_IDX) begin
          flag[wb] <= BANK_FULL;
          wb       <= ~wb;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 4'd1;
        if (rcnt == LAST_IDX) begin
          flag[rb] <= BANK_FREE;
          rb       <= ~rb;
        end
      end
    end
  end

endmodule
